// File: rtl/tawas_regfile_pkg.sv
// Tawas multithreaded register file: shared defaults, FSM state type
// and a constant-evaluable ceil(log2) helper.
package tawas_regfile_pkg;

   localparam int DEF_NTHREADS = 32;
   localparam int DEF_NREGS    = 8;
   localparam int DEF_DW       = 32;
   localparam int DEF_FW       = 8;
   localparam int DEF_NWB      = 4;

   typedef enum logic {
      INIT,
      READY
   } state_e;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/tawas_regfile_wb_merge.sv
// Folds NWB register writeback ports plus the flags port into one
// context-wide data/mask pair and flags same-register port collisions.
// Ports: reg_en_i/reg_sel_i/reg_data_i (per port), flags_en_i/flags_i,
//        wdata_o/wmask_o (CW bits), any_en_o, collision_o.
module tawas_regfile_wb_merge
   import tawas_regfile_pkg::*;
#(
   parameter  int NREGS = DEF_NREGS,
   parameter  int DW    = DEF_DW,
   parameter  int FW    = DEF_FW,
   parameter  int NWB   = DEF_NWB,
   localparam int RW    = clog2(NREGS),
   localparam int CW    = NREGS * DW + FW
)(
   input  logic [NWB-1:0]    reg_en_i,
   input  logic [NWB*RW-1:0] reg_sel_i,
   input  logic [NWB*DW-1:0] reg_data_i,
   input  logic              flags_en_i,
   input  logic [FW-1:0]     flags_i,
   output logic [CW-1:0]     wdata_o,
   output logic [CW-1:0]     wmask_o,
   output logic              any_en_o,
   output logic              collision_o
);

   // Walking registers (not ports) means an out-of-range select never
   // matches any slot and is silently dropped; the ascending port
   // loop lets the highest enabled port win.
   always_comb begin
      int hits;
      wdata_o     = '0;
      wmask_o     = '0;
      collision_o = 1'b0;
      for (int r = 0; r < NREGS; r++) begin
         hits = 0;
         for (int p = 0; p < NWB; p++) begin
            if (reg_en_i[p] && reg_sel_i[p*RW +: RW] == RW'(r)) begin
               hits++;
               wdata_o[r*DW +: DW] = reg_data_i[p*DW +: DW];
               wmask_o[r*DW +: DW] = '1;
            end
         end
         if (hits > 1) collision_o = 1'b1;
      end
      if (flags_en_i) begin
         wdata_o[CW-1 -: FW] = flags_i;
         wmask_o[CW-1 -: FW] = '1;
      end
   end

   assign any_en_o = (|reg_en_i) | flags_en_i;

endmodule

// File: rtl/tawas_regfile_mt.sv
// Multithreaded register file: one NREGS x DW + FW context per thread,
// zero-init sweep after reset, 2-stage writeback RMW, bypassed loads.
// Ports: clk/rst, init_busy, thread_load_en/thread_load -> regs_out/
//        flags_out, wb_* writeback inputs, wb_collision pulse.
module tawas_regfile_mt
   import tawas_regfile_pkg::*;
#(
   parameter  int NTHREADS = DEF_NTHREADS,
   parameter  int NREGS    = DEF_NREGS,
   parameter  int DW       = DEF_DW,
   parameter  int FW       = DEF_FW,
   parameter  int NWB      = DEF_NWB,
   localparam int TW       = clog2(NTHREADS),
   localparam int RW       = clog2(NREGS),
   localparam int CW       = NREGS * DW + FW
)(
   input  logic              clk,
   input  logic              rst,
   output logic              init_busy,
   input  logic              thread_load_en,
   input  logic [TW-1:0]     thread_load,
   output logic [NREGS*DW-1:0] regs_out,
   output logic [FW-1:0]     flags_out,
   input  logic [TW-1:0]     wb_thread,
   input  logic [NWB-1:0]    wb_reg_en,
   input  logic [NWB*RW-1:0] wb_reg_sel,
   input  logic [NWB*DW-1:0] wb_reg_data,
   input  logic              wb_flags_en,
   input  logic [FW-1:0]     wb_flags,
   output logic              wb_collision
);

   state_e        state_q;
   logic [TW-1:0] addr_q;
   logic          wen_q;
   logic [TW-1:0] waddr_q;
   logic [CW-1:0] wdata_q;
   logic [CW-1:0] wmask_q;
   logic [CW-1:0] out_q;
   logic          coll_q;
   logic [CW-1:0] mem_q [NTHREADS];

   logic [CW-1:0] m_wdata;
   logic [CW-1:0] m_wmask;
   logic          m_any;
   logic          m_coll;
   logic          ready;
   logic [CW-1:0] load_d;

   tawas_regfile_wb_merge #(
      .NREGS (NREGS),
      .DW    (DW),
      .FW    (FW),
      .NWB   (NWB)
   ) u_merge (
      .reg_en_i    (wb_reg_en),
      .reg_sel_i   (wb_reg_sel),
      .reg_data_i  (wb_reg_data),
      .flags_en_i  (wb_flags_en),
      .flags_i     (wb_flags),
      .wdata_o     (m_wdata),
      .wmask_o     (m_wmask),
      .any_en_o    (m_any),
      .collision_o (m_coll)
   );

   assign ready = (state_q == READY);

   // Load value: array, then the staged write, then this cycle's
   // merge, so a load observes every writeback presented so far.
   always_comb begin
      load_d = mem_q[thread_load];
      if (wen_q && waddr_q == thread_load)
         load_d = (load_d & ~wmask_q) | wdata_q;
      if (m_any && wb_thread == thread_load)
         load_d = (load_d & ~m_wmask) | m_wdata;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= INIT;
         addr_q  <= '0;
         wen_q   <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
         wmask_q <= '0;
         out_q   <= '0;
         coll_q  <= 1'b0;
      end else begin
         wen_q   <= ready & m_any;
         waddr_q <= wb_thread;
         wdata_q <= m_wdata;
         wmask_q <= m_wmask;
         coll_q  <= ready & m_coll;
         if (ready && thread_load_en) out_q <= load_d;
         unique case (state_q)
            INIT: begin
               addr_q <= addr_q + TW'(1);
               if (addr_q == TW'(NTHREADS - 1)) state_q <= READY;
            end
            READY: ;
            default: state_q <= INIT;
         endcase
      end
   end

   // The array carries no reset; INIT clears it one context per cycle.
   always_ff @(posedge clk) begin
      if (state_q == INIT)
         mem_q[addr_q] <= '0;
      else if (wen_q)
         mem_q[waddr_q] <= (mem_q[waddr_q] & ~wmask_q) | wdata_q;
   end

   assign init_busy    = (state_q == INIT);
   assign regs_out     = out_q[NREGS*DW-1:0];
   assign flags_out    = out_q[CW-1 -: FW];
   assign wb_collision = coll_q;

endmodule

// File: tb/tb_tawas_regfile_mt.sv
// Self-checking bench for tawas_regfile_mt: directed cases plus random
// traffic against an array-of-registers reference model.
module tb_tawas_regfile_mt;

   localparam int NT  = 32;
   localparam int NR  = 8;
   localparam int DW  = 32;
   localparam int FW  = 8;
   localparam int NWB = 4;
   localparam int TW  = 5;
   localparam int RW  = 3;
   localparam int VW  = NR * DW;
   localparam int SW  = NWB * RW;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             init_busy;
   logic             thread_load_en;
   logic [TW-1:0]    thread_load;
   logic [VW-1:0]    regs_out;
   logic [FW-1:0]    flags_out;
   logic [TW-1:0]    wb_thread;
   logic [NWB-1:0]   wb_reg_en;
   logic [SW-1:0]    wb_reg_sel;
   logic [NWB*DW-1:0] wb_reg_data;
   logic             wb_flags_en;
   logic [FW-1:0]    wb_flags;
   logic             wb_collision;

   always #5 clk = ~clk;

   tawas_regfile_mt #(
      .NTHREADS (NT),
      .NREGS    (NR),
      .DW       (DW),
      .FW       (FW),
      .NWB      (NWB)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .init_busy      (init_busy),
      .thread_load_en (thread_load_en),
      .thread_load    (thread_load),
      .regs_out       (regs_out),
      .flags_out      (flags_out),
      .wb_thread      (wb_thread),
      .wb_reg_en      (wb_reg_en),
      .wb_reg_sel     (wb_reg_sel),
      .wb_reg_data    (wb_reg_data),
      .wb_flags_en    (wb_flags_en),
      .wb_flags       (wb_flags),
      .wb_collision   (wb_collision)
   );

   logic [DW-1:0] m_regs [NT][NR];
   logic [FW-1:0] m_flags [NT];
   logic [VW-1:0] e_regs;
   logic [FW-1:0] e_flags;
   logic          e_coll;
   int            k;
   int            n_vec = 0;
   int            n_err = 0;

   task automatic chk(input string tag, input logic [VW-1:0] got,
                      input logic [VW-1:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic idle();
      wb_reg_en      = '0;
      wb_flags_en    = 1'b0;
      thread_load_en = 1'b0;
   endtask

   task automatic wr(input int p, input int t, input int r,
                     input logic [DW-1:0] d);
      wb_thread              = TW'(t);
      wb_reg_en[p]           = 1'b1;
      wb_reg_sel[p*RW +: RW] = RW'(r);
      wb_reg_data[p*DW +: DW] = d;
   endtask

   task automatic ld(input int t);
      thread_load_en = 1'b1;
      thread_load    = TW'(t);
   endtask

   task automatic rand_inputs(input int tmax);
      wb_reg_en      = NWB'($urandom);
      wb_reg_sel     = SW'($urandom);
      wb_reg_data    = {$urandom, $urandom, $urandom, $urandom};
      wb_flags_en    = ($urandom_range(0, 3) == 0);
      wb_flags       = FW'($urandom);
      wb_thread      = TW'($urandom_range(0, tmax));
      thread_load_en = ($urandom_range(0, 1) == 1);
      thread_load    = TW'($urandom_range(0, tmax));
   endtask

   // Model: once the sweep is over, this cycle's writes land in the
   // context immediately (ports in ascending order, last one wins) and
   // a load returns the updated context after the next edge.
   task automatic cycle();
      int hits [NR];
      int r;
      e_coll = 1'b0;
      if (k >= NT) begin
         for (int i = 0; i < NR; i++) hits[i] = 0;
         for (int p = 0; p < NWB; p++) begin
            if (wb_reg_en[p]) begin
               r = int'(wb_reg_sel[p*RW +: RW]);
               hits[r]++;
               m_regs[wb_thread][r] = wb_reg_data[p*DW +: DW];
            end
         end
         if (wb_flags_en) m_flags[wb_thread] = wb_flags;
         for (int i = 0; i < NR; i++)
            if (hits[i] > 1) e_coll = 1'b1;
         if (thread_load_en) begin
            for (int i = 0; i < NR; i++)
               e_regs[i*DW +: DW] = m_regs[thread_load][i];
            e_flags = m_flags[thread_load];
         end
      end
      @(posedge clk);
      #1;
      k++;
      chk("busy", VW'(init_busy), VW'(k < NT));
      chk("regs", regs_out, e_regs);
      chk("flags", VW'(flags_out), VW'(e_flags));
      chk("coll", VW'(wb_collision), VW'(e_coll));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      chk("rst_busy", VW'(init_busy), VW'(1));
      chk("rst_regs", regs_out, '0);
      chk("rst_flags", VW'(flags_out), '0);
      chk("rst_coll", VW'(wb_collision), '0);
      for (int t = 0; t < NT; t++) begin
         m_flags[t] = '0;
         for (int i = 0; i < NR; i++) m_regs[t][i] = '0;
      end
      e_regs  = '0;
      e_flags = '0;
      e_coll  = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      k   = 0;
   endtask

   task automatic sweep();
      repeat (NT) begin
         rand_inputs(NT - 1);
         cycle();
      end
   endtask

   initial begin
      logic [VW-1:0] exp_v;
      wb_thread   = '0;
      thread_load = '0;
      wb_reg_sel  = '0;
      wb_reg_data = '0;
      wb_flags    = '0;
      idle();
      k = 0;
      #2;
      do_reset();
      sweep();

      idle(); ld(31); cycle();
      chk("t31_regs", regs_out, '0);
      chk("t31_flags", VW'(flags_out), '0);

      idle(); wr(0, 5, 3, 32'hDEADBEEF); cycle();
      idle(); cycle(); cycle();
      ld(5); cycle();
      exp_v = '0;
      exp_v[3*DW +: DW] = 32'hDEADBEEF;
      chk("t5_ctx", regs_out, exp_v);

      idle(); wr(0, 7, 1, 32'h1234); ld(7); cycle();
      chk("byp_same", VW'(regs_out[DW +: DW]), VW'(32'h1234));
      idle(); wr(1, 8, 1, 32'h1234); cycle();
      idle(); ld(8); cycle();
      chk("byp_next", VW'(regs_out[DW +: DW]), VW'(32'h1234));

      idle(); wr(0, 2, 4, 32'hA0A0); wr(2, 2, 4, 32'hC2C2); cycle();
      chk("coll_hi", VW'(wb_collision), VW'(1));
      idle(); cycle();
      chk("coll_lo", VW'(wb_collision), '0);
      ld(2); cycle();
      chk("coll_win", VW'(regs_out[4*DW +: DW]), VW'(32'hC2C2));

      idle(); wr(1, 3, 0, 32'h1);
      wb_flags_en = 1'b1; wb_flags = 8'h5A; cycle();
      idle(); wr(3, 3, 7, 32'hFFFF_FFFF); cycle();
      idle(); ld(3); cycle();
      exp_v = '0;
      exp_v[0 +: DW]    = 32'h1;
      exp_v[7*DW +: DW] = 32'hFFFF_FFFF;
      chk("part_regs", regs_out, exp_v);
      chk("part_flags", VW'(flags_out), VW'(8'h5A));

      for (int i = 0; i < 1500; i++) begin
         rand_inputs(3);
         cycle();
      end
      for (int i = 0; i < 400; i++) begin
         rand_inputs(NT - 1);
         cycle();
      end

      idle(); wr(0, 9, 2, 32'h99); wr(1, 9, 2, 32'h98); cycle();
      do_reset();
      repeat (10) begin
         rand_inputs(NT - 1);
         cycle();
      end
      do_reset();
      sweep();
      idle(); ld(9); cycle();
      chk("t9_zero", regs_out, '0);
      chk("t9_flags", VW'(flags_out), '0);
      chk("t9_coll", VW'(wb_collision), '0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
